// File: rtl/pipeline_pkg.sv
// pipeline_pkg: constants and types shared by the pipeline stages
package pipeline_pkg;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  typedef enum logic [1:0] {RUN, PEND, SQUASH} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: one-entry holding slot for a fetched instruction and its PC+4
module fetch_buffer
  import pipeline_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] instr_in,
  input  logic [31:0] pcp4_in,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pcp4
);
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      full <= 1'b0;
      instr <= NOP_WORD;
      pcp4 <= '0;
    end else begin
      if (load) begin
        instr <= instr_in;
        pcp4 <= pcp4_in;
      end
      full <= load || (full && !drain);
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives the instruction-memory handshake and the IF/ID register,
// and applies taken branch/jump redirects after the delay slot.
module fetch_stage
  import pipeline_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        STALL_IFID,
  input  logic        FLUSH_IFID,
  input  logic        Redirect_IN,
  input  logic [31:0] RedirectTarget_IN,
  output logic        IMemReq_OUT,
  output logic [31:0] IMemAddr_OUT,
  input  logic        IMemReady_IN,
  input  logic [31:0] IMemData_IN,
  output logic [31:0] Instruction_OUT,
  output logic [31:0] PCPlus4_OUT,
  output logic        Valid_OUT
);
  fetch_state_t state, state_n;
  logic        active, seen, accept, capture, hit_slot, hit_next, squash, keep;
  logic        buf_full, buf_load, buf_drain;
  logic [31:0] pc, pc_plus4, next_pc, target, redirect_tgt, buf_instr, buf_pcp4;

  assign IMemAddr_OUT = pc;
  assign pc_plus4 = pc + 32'd4;

  fetch_buffer u_buf (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .load     (buf_load),
    .drain    (buf_drain),
    .instr_in (IMemData_IN),
    .pcp4_in  (pc_plus4),
    .full     (buf_full),
    .instr    (buf_instr),
    .pcp4     (buf_pcp4)
  );

  // The slot is at PCPlus4_OUT: fetching it now means the redirect waits for that
  // response; fetching the word after it means the slot is buffered and the outstanding word dies.
  always_comb begin
    buf_drain = buf_full && !STALL_IFID && !FLUSH_IFID;
    IMemReq_OUT = active && (!buf_full || buf_drain);
    accept = IMemReq_OUT && IMemReady_IN;
    capture = Redirect_IN && Valid_OUT && !seen && state == RUN;
    hit_slot = capture && pc == PCPlus4_OUT;
    hit_next = capture && pc == PCPlus4_OUT + 32'd4;
    squash = accept && (state == SQUASH || hit_next);
    keep = accept && !squash;
    buf_load = keep && (buf_full || STALL_IFID || FLUSH_IFID);
    redirect_tgt = state == RUN ? RedirectTarget_IN : target;
    next_pc = !accept ? pc : (squash || hit_slot || state == PEND) ? redirect_tgt : pc_plus4;
    state_n = accept ? RUN : hit_slot ? PEND : hit_next ? SQUASH : state;
  end

  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      active <= 1'b0;
      pc <= RESET_PC;
      state <= RUN;
      target <= '0;
      seen <= 1'b0;
      Instruction_OUT <= NOP_WORD;
      PCPlus4_OUT <= '0;
      Valid_OUT <= 1'b0;
    end else begin
      active <= 1'b1;
      pc <= next_pc;
      state <= state_n;
      if (capture) target <= RedirectTarget_IN;
      seen <= STALL_IFID && !FLUSH_IFID && (seen || capture);
      if (FLUSH_IFID || (!STALL_IFID && !buf_full && !keep)) begin
        Instruction_OUT <= NOP_WORD;
        Valid_OUT <= 1'b0;
      end else if (!STALL_IFID) begin
        Instruction_OUT <= buf_full ? buf_instr : IMemData_IN;
        PCPlus4_OUT <= buf_full ? buf_pcp4 : pc_plus4;
        Valid_OUT <= 1'b1;
      end
    end
endmodule
